operand_read_sequencer: RTL

- Per-operand-queue read sequencer, directly upstream of the lane operand queue.
- Accepts one operand-read request per vector instruction and immediately forwards the matching queue command.
- Issues one VRF read per 64-bit word, only while the downstream queue has credit, and pulses operand_issued_o for each read the VRF grants.
- One instance sits between the lane sequencer and each operand queue.

---
 rtl/operand_read_sequencer_if.sv | 48 ++++
 rtl/operand_read_sequencer.sv | 103 ++++++++++
 2 files changed

// File: rtl/operand_read_sequencer_if.sv
// rtl/operand_read_sequencer_if.sv - request, queue-command and VRF-read bundle; hazard_i exists only under OPREQ_HAZARD_STALL_EN
interface operand_read_sequencer_if #(
    parameter int VlWidth   = 16,
    parameter int AddrWidth = 10
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [4:0]           req_vs_i;
    logic [1:0]           req_eew_i;
    logic [VlWidth-1:0]   req_vl_i;
    logic [3:0]           req_conv_i;
    logic [1:0]           req_ntr_red_i;
    logic                 req_target_fu_i;
    logic                 cmd_valid_o;
    logic [1:0]           cmd_eew_o;
    logic [VlWidth-1:0]   cmd_vl_o;
    logic [3:0]           cmd_conv_o;
    logic [1:0]           cmd_ntr_red_o;
    logic                 cmd_target_fu_o;
    logic                 operand_queue_ready_i;
    logic                 vrf_req_o;
    logic [AddrWidth-1:0] vrf_addr_o;
    logic                 vrf_gnt_i;
    logic                 operand_issued_o;
`ifdef OPREQ_HAZARD_STALL_EN
    logic                 hazard_i;
`endif

    modport slave (
        input  req_valid_i, req_vs_i, req_eew_i, req_vl_i, req_conv_i, req_ntr_red_i,
               req_target_fu_i, operand_queue_ready_i, vrf_gnt_i,
`ifdef OPREQ_HAZARD_STALL_EN
               hazard_i,
`endif
        output req_ready_o, cmd_valid_o, cmd_eew_o, cmd_vl_o, cmd_conv_o, cmd_ntr_red_o,
               cmd_target_fu_o, vrf_req_o, vrf_addr_o, operand_issued_o
    );

    modport master (
        output req_valid_i, req_vs_i, req_eew_i, req_vl_i, req_conv_i, req_ntr_red_i,
               req_target_fu_i, operand_queue_ready_i, vrf_gnt_i,
`ifdef OPREQ_HAZARD_STALL_EN
               hazard_i,
`endif
        input  req_ready_o, cmd_valid_o, cmd_eew_o, cmd_vl_o, cmd_conv_o, cmd_ntr_red_o,
               cmd_target_fu_o, vrf_req_o, vrf_addr_o, operand_issued_o
    );
endinterface

// File: rtl/operand_read_sequencer.sv
// rtl/operand_read_sequencer.sv - per-operand-queue VRF read sequencer; OPREQ_HAZARD_STALL_EN adds a hazard stall input
module operand_read_sequencer #(
    parameter int VlWidth     = 16,
    parameter int AddrWidth   = 10,
    parameter int WordsPerReg = 32
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    operand_read_sequencer_if.slave bus
);
    typedef enum logic {IDLE, ISSUE} state_e;

    localparam int CntWidth = VlWidth + 3;

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  bytes, words, words_q, cnt_q;
    logic [AddrWidth-1:0] base, addr_q;
    logic                 accept, accept_cmd, issue_en, grant, last;
    logic                 cmd_valid_q;
    logic [1:0]           cmd_eew_q;
    logic [VlWidth-1:0]   cmd_vl_q;
    logic [3:0]           cmd_conv_q;
    logic [1:0]           cmd_ntr_red_q;
    logic                 cmd_target_fu_q;
    logic                 stall;

    assign bytes = {3'b000, bus.req_vl_i} << bus.req_eew_i;
    assign words = (bytes + CntWidth'(7)) >> 3;
    assign base  = AddrWidth'(32'(bus.req_vs_i) * WordsPerReg);

`ifdef OPREQ_HAZARD_STALL_EN
    assign stall = !bus.operand_queue_ready_i || bus.hazard_i;
`else
    assign stall = !bus.operand_queue_ready_i;
`endif

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        accept_cmd = 1'b0;
        issue_en   = 1'b0;
        grant      = 1'b0;
        last       = 1'b0;
        case (state_q)
            IDLE: begin
                accept     = bus.req_valid_i;
                accept_cmd = accept && (bus.req_vl_i != '0);
                if (accept_cmd) state_d = ISSUE;
            end
            ISSUE: begin
                // Outputs are forced quiet while reset is asserted, even mid-command
                issue_en = rst_ni && !stall;
                grant    = issue_en && bus.vrf_gnt_i;
                last     = grant && (cnt_q == words_q - CntWidth'(1));
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            words_q         <= '0;
            addr_q          <= '0;
            cmd_valid_q     <= 1'b0;
            cmd_eew_q       <= '0;
            cmd_vl_q        <= '0;
            cmd_conv_q      <= '0;
            cmd_ntr_red_q   <= '0;
            cmd_target_fu_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= accept_cmd;
            if (accept_cmd) begin
                cnt_q           <= '0;
                words_q         <= words;
                addr_q          <= base;
                cmd_eew_q       <= bus.req_eew_i;
                cmd_vl_q        <= bus.req_vl_i;
                cmd_conv_q      <= bus.req_conv_i;
                cmd_ntr_red_q   <= bus.req_ntr_red_i;
                cmd_target_fu_q <= bus.req_target_fu_i;
            end else if (grant) begin
                cnt_q <= cnt_q + CntWidth'(1);
                // The final address stays visible while idle
                if (!last) addr_q <= addr_q + AddrWidth'(1);
            end
        end
    end

    assign bus.req_ready_o      = !rst_ni || (state_q == IDLE);
    assign bus.cmd_valid_o      = rst_ni && cmd_valid_q;
    assign bus.cmd_eew_o        = cmd_eew_q;
    assign bus.cmd_vl_o         = cmd_vl_q;
    assign bus.cmd_conv_o       = cmd_conv_q;
    assign bus.cmd_ntr_red_o    = cmd_ntr_red_q;
    assign bus.cmd_target_fu_o  = cmd_target_fu_q;
    assign bus.vrf_req_o        = issue_en;
    assign bus.vrf_addr_o       = addr_q;
    assign bus.operand_issued_o = grant;
endmodule
